// File: rtl/cgra_mul_pkg.sv
// Shared definitions for the time-shared multiplier scheduler.
package cgra_mul_pkg;

  localparam logic [4:0] MUL_OPCODE = 5'b00011;

  // Tag width that never collapses to zero bits for a single requester.
  function automatic int unsigned tag_w(input int unsigned num_req);
    return (num_req > 1) ? int'($clog2(num_req)) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above i_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_pos >= (IDX_W + 1)'(N)) begin
        w_pos = w_pos - (IDX_W + 1)'(N);
      end
      if (!o_any && i_req[w_pos[IDX_W-1:0]]) begin
        o_any                    = 1'b1;
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                    = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_mul_scheduler.sv
// One pipelined signed multiplier shared round-robin among NUM_REQ requesters,
// with a fixed-latency, one-hot tagged response.
module shared_mul_scheduler
  import cgra_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          stall,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          busy
);

  localparam int unsigned TAG_W = tag_w(NUM_REQ);

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] data;
  } mul_pipe_entry_t;

  mul_pipe_entry_t       r_pipe [MUL_LATENCY];
  logic [TAG_W-1:0]      r_rr_ptr;

  logic [NUM_REQ-1:0]    w_grant;
  logic [TAG_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_accept;
  logic [TAG_W-1:0]      w_ptr_next;
  logic [DATA_WIDTH-1:0] w_rhs;
  logic [DATA_WIDTH-1:0] w_lhs;
  logic [DATA_WIDTH-1:0] w_prod;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready  = stall ? '0 : w_grant;
  assign w_accept   = w_any & ~stall;
  assign w_ptr_next = (w_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  assign w_rhs  = req_rhs[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_lhs  = req_lhs[w_idx*DATA_WIDTH +: DATA_WIDTH];
  // Same-width signed product keeps only the low DATA_WIDTH bits, i.e. wraps.
  assign w_prod = $signed(w_rhs) * $signed(w_lhs);

  // Bubbles advance only the valid bit so the last stage keeps its data for resp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (!stall) begin
      if (w_accept) begin
        r_rr_ptr       <= w_ptr_next;
        r_pipe[0].tag  <= w_idx;
        r_pipe[0].data <= w_prod;
      end
      r_pipe[0].valid <= w_accept;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_pipe[i].valid <= r_pipe[i-1].valid;
        if (r_pipe[i-1].valid) begin
          r_pipe[i].tag  <= r_pipe[i-1].tag;
          r_pipe[i].data <= r_pipe[i-1].data;
        end
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = r_pipe[MUL_LATENCY-1].valid && (r_pipe[MUL_LATENCY-1].tag == TAG_W'(i));
    end
  end

  assign resp_data = r_pipe[MUL_LATENCY-1].data;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      busy = busy | r_pipe[i].valid;
    end
  end

endmodule
